h80bus_arbiter: RTL and testbench

//  Two-master front end for the h80 memory bus. Sits directly upstream of the bus memory.

---
 rtl/h80bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_h80bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h80bus_arbiter.sv
// h80bus_arbiter
// Two-master front end for the h80 memory bus. Arbitrates the CPU data port
// (m0) and the instruction-fetch port (m1) onto a single ce_n/addr/cmd/data
// bus and sequences each access through ADDR, DATA (reads only) and DONE.
// All bus-facing outputs and master acks are registered.
//
// Build option:
//   H80BUS_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                     undefined -> fixed priority, m0 wins every tie
module h80bus_arbiter #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      m0_req,
    input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
    output logic                      m0_ack,
    output logic [BUS_DATA_WIDTH-1:0] m0_rdata,

    input  logic                      m1_req,
    input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
    output logic                      m1_ack,
    output logic [BUS_DATA_WIDTH-1:0] m1_rdata,

    output logic                      bus_ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
    output logic [BUS_CMD_WIDTH-1:0]  bus_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] bus_data_,
    input  logic                      bus_wait_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // FSM state
    state_t                    r_state;
    state_t                    w_state_nxt;

    // Latched access of the granted master (0 = m0, 1 = m1)
    logic                      r_gnt;
    logic [BUS_ADDR_WIDTH-1:0] r_addr;
    logic [BUS_CMD_WIDTH-1:0]  r_cmd;
    logic [BUS_DATA_WIDTH-1:0] r_wdata;

    // Registered bus controls and master responses
    logic                      r_ce_n;
    logic                      r_drive;
    logic                      r_m0_ack;
    logic                      r_m1_ack;
    logic [BUS_DATA_WIDTH-1:0] r_m0_rdata;
    logic [BUS_DATA_WIDTH-1:0] r_m1_rdata;

    // Arbitration and next-cycle output values
    logic                      w_any_req;
    logic                      w_grant;
    logic                      w_win;
    logic                      w_capture;
    logic [BUS_ADDR_WIDTH-1:0] w_sel_addr;
    logic [BUS_CMD_WIDTH-1:0]  w_sel_cmd;
    logic [BUS_DATA_WIDTH-1:0] w_sel_wdata;
    logic                      w_rd_nxt;
    logic                      w_ce_n_nxt;
    logic                      w_drive_nxt;
    logic                      w_m0_ack_nxt;
    logic                      w_m1_ack_nxt;

    assign w_any_req = m0_req | m1_req;
    assign w_grant   = (r_state == ST_IDLE) && w_any_req;
    // Read data is taken on the DATA cycle the slave does not stall
    assign w_capture = (r_state == ST_DATA) && bus_wait_n;

`ifdef H80BUS_ARB_RR_EN
    logic r_last_gnt;

    // Remember the winner of the most recent arbitration (m1 out of reset)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_grant) begin
            r_last_gnt <= w_win;
        end else begin
            r_last_gnt <= r_last_gnt;
        end
    end

    // Round-robin: on a tie the master that did not win last time goes next
    always_comb begin
        w_win = 1'b0;
        if (m0_req && m1_req) begin
            w_win = ~r_last_gnt;
        end else if (m0_req) begin
            w_win = 1'b0;
        end else begin
            w_win = 1'b1;
        end
    end
`else
    // Fixed priority: m1 is chosen only when m0 is not requesting
    always_comb begin
        w_win = 1'b0;
        if (m0_req) begin
            w_win = 1'b0;
        end else begin
            w_win = 1'b1;
        end
    end
`endif

    // Route the winning master's request fields toward the latch
    always_comb begin
        w_sel_addr  = m0_addr;
        w_sel_cmd   = m0_cmd;
        w_sel_wdata = m0_wdata;
        if (w_win) begin
            w_sel_addr  = m1_addr;
            w_sel_cmd   = m1_cmd;
            w_sel_wdata = m1_wdata;
        end else begin
            w_sel_addr  = m0_addr;
            w_sel_cmd   = m0_cmd;
            w_sel_wdata = m0_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a granted access always runs to DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (!bus_wait_n) begin
                    w_state_nxt = ST_ADDR;
                end else if (r_cmd[0]) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DATA: begin
                if (bus_wait_n) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: values the bus and acks must take in the next state
    always_comb begin
        w_rd_nxt     = r_cmd[0];
        w_ce_n_nxt   = 1'b1;
        w_drive_nxt  = 1'b0;
        w_m0_ack_nxt = 1'b0;
        w_m1_ack_nxt = 1'b0;
        // Entering ADDR from IDLE the command is not latched yet
        if (r_state == ST_IDLE) begin
            w_rd_nxt = w_sel_cmd[0];
        end else begin
            w_rd_nxt = r_cmd[0];
        end
        case (w_state_nxt)
            ST_ADDR: begin
                w_ce_n_nxt  = 1'b0;
                w_drive_nxt = ~w_rd_nxt;
            end
            ST_DATA: begin
                w_ce_n_nxt  = 1'b0;
            end
            ST_DONE: begin
                w_m0_ack_nxt = ~r_gnt;
                w_m1_ack_nxt = r_gnt;
            end
            default: begin
                w_ce_n_nxt  = 1'b1;
            end
        endcase
    end

    // Latch the winner's request at grant; held for the whole access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt   <= 1'b0;
            r_addr  <= {BUS_ADDR_WIDTH{1'b0}};
            r_cmd   <= {BUS_CMD_WIDTH{1'b0}};
            r_wdata <= {BUS_DATA_WIDTH{1'b0}};
        end else if (w_grant) begin
            r_gnt   <= w_win;
            r_addr  <= w_sel_addr;
            r_cmd   <= w_sel_cmd;
            r_wdata <= w_sel_wdata;
        end else begin
            r_gnt   <= r_gnt;
            r_addr  <= r_addr;
            r_cmd   <= r_cmd;
            r_wdata <= r_wdata;
        end
    end

    // Register bus strobe, data-drive enable and completion pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ce_n   <= 1'b1;
            r_drive  <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
        end else begin
            r_ce_n   <= w_ce_n_nxt;
            r_drive  <= w_drive_nxt;
            r_m0_ack <= w_m0_ack_nxt;
            r_m1_ack <= w_m1_ack_nxt;
        end
    end

    // Capture read data into the granted master's holding register only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m0_rdata <= {BUS_DATA_WIDTH{1'b0}};
            r_m1_rdata <= {BUS_DATA_WIDTH{1'b0}};
        end else if (w_capture && !r_gnt) begin
            r_m0_rdata <= bus_data_;
            r_m1_rdata <= r_m1_rdata;
        end else if (w_capture && r_gnt) begin
            r_m0_rdata <= r_m0_rdata;
            r_m1_rdata <= bus_data_;
        end else begin
            r_m0_rdata <= r_m0_rdata;
            r_m1_rdata <= r_m1_rdata;
        end
    end

    // Drive data only during a write ADDR phase so the slave owns reads
    assign bus_data_ = r_drive ? r_wdata : {BUS_DATA_WIDTH{1'bz}};

    assign bus_ce_n  = r_ce_n;
    assign bus_addr  = r_addr;
    assign bus_cmd   = r_cmd;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_h80bus_arbiter.sv
// Self-checking bench for h80bus_arbiter: directed scenarios plus randomized
// single-master accesses against a transaction-level model (memory map,
// last-grant, latency rule derived from the wait_n pattern).
module tb_h80bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m1_req, m0_ack, m1_ack;
    logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [2:0]  m0_cmd, m1_cmd, bus_cmd;
    logic        bus_ce_n, bus_wait_n;
    logic [15:0] bus_addr;
    wire  [15:0] bus_data_;

    int n_checks;
    int n_errors;

    // Slave memory (environment) and reference model state
    logic [15:0] slv_mem [0:255];
    logic [15:0] mdl_mem [int];
    logic [15:0] exp_rd0, exp_rd1;
    int          mdl_last;

    h80bus_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_cmd     (m0_cmd),
        .m0_wdata   (m0_wdata),
        .m0_ack     (m0_ack),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_cmd     (m1_cmd),
        .m1_wdata   (m1_wdata),
        .m1_ack     (m1_ack),
        .m1_rdata   (m1_rdata),
        .bus_ce_n   (bus_ce_n),
        .bus_addr   (bus_addr),
        .bus_cmd    (bus_cmd),
        .bus_data_  (bus_data_),
        .bus_wait_n (bus_wait_n)
    );

    always #5 clk = ~clk;

    // Slave: parks 0 on the bus while deselected, returns memory on reads
    assign bus_data_ = bus_ce_n ? 16'h0000 : (bus_cmd[0] ? slv_mem[bus_addr[7:0]] : 16'hzzzz);

    always @(posedge clk) begin
        if (!bus_ce_n && !bus_cmd[0] && bus_wait_n) slv_mem[bus_addr[7:0]] <= bus_data_;
    end

    function automatic logic [15:0] mdl_rd(input logic [15:0] a);
        if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
        return 16'h0000;
    endfunction

    // Latency rule: count non-stalled ADDR/DATA cycles needed, ack one later
    function automatic int exp_lat(input logic [2:0] cmd, input logic [15:0] pat);
        int need = cmd[0] ? 2 : 1;
        int got  = 0;
        for (int i = 0; i < 64; i++) begin
            if ((i < 16) ? pat[i] : 1'b1) begin
                got++;
                if (got == need) return i + 2;
            end
        end
        return -1;
    endfunction

    task automatic mdl_commit(input int mst, input logic [2:0] cmd, input logic [15:0] addr,
                              input logic [15:0] wdata);
        if (cmd[0]) begin
            if (mst == 0) exp_rd0 = mdl_rd(addr); else exp_rd1 = mdl_rd(addr);
        end else begin
            mdl_mem[int'(addr)] = wdata;
        end
        mdl_last = mst;
    endtask

    task automatic present(input int mst, input logic [2:0] cmd, input logic [15:0] addr,
                           input logic [15:0] wdata);
        if (mst == 0) begin
            m0_req = 1'b1; m0_cmd = cmd; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_cmd = cmd; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic drop(input int mst);
        if (mst == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    // Drive one access from one master and collect observations (no checks here).
    // pat[k-1] is the wait_n value sampled at the k-th edge after the grant edge.
    task automatic run_access(input int mst, input logic [2:0] cmd, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] pat, input bit drop_early,
                              output int lat, output logic [15:0] rd, output int ce_low,
                              output bit bus_bad, output bit other_ack, output logic [15:0] wseen,
                              output int ack_cnt);
        lat = 0; rd = 16'h0000; ce_low = 0; bus_bad = 1'b0; other_ack = 1'b0;
        wseen = 16'h0000; ack_cnt = 0;
        @(negedge clk);
        bus_wait_n = 1'b1;
        present(mst, cmd, addr, wdata);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (drop_early && k == 1) drop(mst);
            bus_wait_n = (k <= 16) ? pat[k-1] : 1'b1;
            if (!bus_ce_n) begin
                ce_low++;
                if (bus_addr !== addr || bus_cmd !== cmd) bus_bad = 1'b1;
                if (!cmd[0]) begin
                    if (ce_low == 1) wseen = bus_data_;
                    if (bus_data_ !== wdata) bus_bad = 1'b1;
                end else if (bus_data_ !== slv_mem[addr[7:0]]) begin
                    bus_bad = 1'b1;
                end
            end else if (bus_data_ !== 16'h0000) begin
                bus_bad = 1'b1;
            end
            if ((mst == 0 ? m0_ack : m1_ack) === 1'b1) begin
                ack_cnt++;
                if (lat == 0) lat = k;
                rd = (mst == 0) ? m0_rdata : m1_rdata;
                drop(mst);
            end
            if ((mst == 0 ? m1_ack : m0_ack) !== 1'b0) other_ack = 1'b1;
            if (lat != 0 && k >= lat + 2) break;
        end
        bus_wait_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_ce_n !== 1'b1) begin n_errors++; $display("FAIL rst_ce_n: got %b expected 1", bus_ce_n); end
        n_checks++; if (bus_addr !== 16'h0000 || bus_cmd !== 3'b000) begin n_errors++; $display("FAIL rst_addr_cmd: got %h/%b expected 0000/000", bus_addr, bus_cmd); end
        n_checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_errors++; $display("FAIL rst_ack: got %b%b expected 00", m0_ack, m1_ack); end
        n_checks++; if (m0_rdata !== 16'h0000 || m1_rdata !== 16'h0000) begin n_errors++; $display("FAIL rst_rdata: got %h/%h expected 0000/0000", m0_rdata, m1_rdata); end
        n_checks++; if (bus_data_ !== 16'h0000) begin n_errors++; $display("FAIL rst_bus_data: got %h expected 0000 (undriven by arbiter)", bus_data_); end
        reset_n = 1'b1;
        mdl_last = 1; exp_rd0 = 16'h0000; exp_rd1 = 16'h0000;
    endtask

    task automatic test_write();
        int lat, ce_low, ack_cnt; logic [15:0] rd, wseen; bit bad, oth;
        run_access(0, 3'b010, 16'h0100, 16'hBEEF, 16'hFFFF, 1'b0, lat, rd, ce_low, bad, oth, wseen, ack_cnt);
        mdl_commit(0, 3'b010, 16'h0100, 16'hBEEF);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        n_checks++; if (ce_low !== 1) begin n_errors++; $display("FAIL wr_ce_low: got %0d cycles expected 1", ce_low); end
        n_checks++; if (wseen !== 16'hBEEF || bad) begin n_errors++; $display("FAIL wr_bus_data: got %h bad=%b expected BEEF bad=0", wseen, bad); end
        n_checks++; if (oth || ack_cnt !== 1) begin n_errors++; $display("FAIL wr_acks: m1_ack_seen=%b m0_acks=%0d expected 0/1", oth, ack_cnt); end
    endtask

    task automatic test_read();
        int lat, ce_low, ack_cnt; logic [15:0] rd, wseen; bit bad, oth;
        run_access(1, 3'b011, 16'h0100, 16'h0000, 16'hFFFF, 1'b0, lat, rd, ce_low, bad, oth, wseen, ack_cnt);
        mdl_commit(1, 3'b011, 16'h0100, 16'h0000);
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        n_checks++; if (rd !== exp_rd1) begin n_errors++; $display("FAIL rd_data: got %h expected %h", rd, exp_rd1); end
        n_checks++; if (bad) begin n_errors++; $display("FAIL rd_bus: got bad=1 expected arbiter never driving"); end
        n_checks++; if (m0_rdata !== exp_rd0 || oth) begin n_errors++; $display("FAIL rd_other: got m0_rdata=%h ack=%b expected %h/0", m0_rdata, oth, exp_rd0); end
    endtask

    task automatic test_wait_data();
        int lat, ce_low, ack_cnt; logic [15:0] rd, wseen; bit bad, oth;
        run_access(0, 3'b011, 16'h0100, 16'h0000, 16'hFFF1, 1'b0, lat, rd, ce_low, bad, oth, wseen, ack_cnt);
        mdl_commit(0, 3'b011, 16'h0100, 16'h0000);
        n_checks++; if (lat !== exp_lat(3'b011, 16'hFFF1)) begin n_errors++; $display("FAIL wait_latency: got %0d expected %0d", lat, exp_lat(3'b011, 16'hFFF1)); end
        n_checks++; if (rd !== exp_rd0) begin n_errors++; $display("FAIL wait_data: got %h expected %h", rd, exp_rd0); end
        n_checks++; if (bad || ce_low !== 5) begin n_errors++; $display("FAIL wait_bus_stable: got bad=%b ce_low=%0d expected 0/5", bad, ce_low); end
    endtask

    task automatic test_back_to_back();
        int exp_q[$], obs_q[$];
        int c0 = 4, c1 = 4, last = mdl_last, g, i0 = 0, i1 = 0;
        logic [15:0] wd [4];
        logic [15:0] e;
        while (c0 > 0 || c1 > 0) begin
            if (c0 > 0 && c1 > 0) begin
`ifdef H80BUS_ARB_RR_EN
                g = (last == 1) ? 0 : 1;
`else
                g = 0;
`endif
            end else begin
                g = (c0 > 0) ? 0 : 1;
            end
            exp_q.push_back(g);
            if (g == 0) c0--; else c1--;
            last = g;
        end
        for (int i = 0; i < 4; i++) wd[i] = 16'($urandom);
        @(negedge clk);
        bus_wait_n = 1'b1;
        present(0, 3'b010, 16'h0180, wd[0]);
        present(1, 3'b011, 16'h0100, 16'h0000);
        for (int t = 0; t < 200 && obs_q.size() < 8; t++) begin
            @(negedge clk);
            if (m0_ack === 1'b1) begin
                obs_q.push_back(0);
                mdl_commit(0, 3'b010, 16'h0180 + 16'(2 * i0), wd[i0]);
                i0++;
                if (i0 < 4) present(0, 3'b010, 16'h0180 + 16'(2 * i0), wd[i0]); else drop(0);
            end
            if (m1_ack === 1'b1) begin
                obs_q.push_back(1);
                e = mdl_rd(16'h0100 + 16'(2 * i1));
                mdl_commit(1, 3'b011, 16'h0100 + 16'(2 * i1), 16'h0000);
                n_checks++; if (m1_rdata !== e) begin n_errors++; $display("FAIL b2b_m1_rdata[%0d]: got %h expected %h", i1, m1_rdata, e); end
                i1++;
                if (i1 < 4) present(1, 3'b011, 16'h0100 + 16'(2 * i1), 16'h0000); else drop(1);
            end
        end
        drop(0); drop(1);
        repeat (2) @(negedge clk);
        n_checks++; if (obs_q.size() !== 8) begin n_errors++; $display("FAIL b2b_count: got %0d grants expected 8", obs_q.size()); end
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_order[%0d]: got m%0d expected m%0d", i, obs_q[i], exp_q[i]); end
        end
        mdl_last = last;
    endtask

    task automatic test_drop_req();
        int lat, ce_low, ack_cnt; logic [15:0] rd, wseen; bit bad, oth;
        run_access(1, 3'b011, 16'h0100, 16'h0000, 16'hFFFF, 1'b1, lat, rd, ce_low, bad, oth, wseen, ack_cnt);
        mdl_commit(1, 3'b011, 16'h0100, 16'h0000);
        n_checks++; if (lat !== 3 || ack_cnt !== 1) begin n_errors++; $display("FAIL drop_ack: got lat=%0d acks=%0d expected 3/1", lat, ack_cnt); end
        n_checks++; if (rd !== exp_rd1 || ce_low !== 2) begin n_errors++; $display("FAIL drop_complete: got rdata=%h ce_low=%0d expected %h/2", rd, ce_low, exp_rd1); end
    endtask

    task automatic test_reset_mid();
        int lat, ce_low, ack_cnt; logic [15:0] rd, wseen; bit bad, oth;
        @(negedge clk);
        bus_wait_n = 1'b1;
        present(0, 3'b011, 16'h0100, 16'h0000);
        @(negedge clk);
        @(negedge clk); bus_wait_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_ce_n !== 1'b0) begin n_errors++; $display("FAIL rstmid_pre: got ce_n=%b expected 0 in DATA", bus_ce_n); end
        reset_n = 1'b0; drop(0);
        #1;
        n_checks++; if (bus_ce_n !== 1'b1 || bus_data_ !== 16'h0000) begin n_errors++; $display("FAIL rstmid_bus: got ce_n=%b data=%h expected 1/0000", bus_ce_n, bus_data_); end
        n_checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_errors++; $display("FAIL rstmid_ack: got %b%b expected 00", m0_ack, m1_ack); end
        n_checks++; if (m0_rdata !== 16'h0000 || m1_rdata !== 16'h0000) begin n_errors++; $display("FAIL rstmid_rdata: got %h/%h expected 0000/0000", m0_rdata, m1_rdata); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1; bus_wait_n = 1'b1;
        exp_rd0 = 16'h0000; exp_rd1 = 16'h0000; mdl_last = 1;
        run_access(1, 3'b011, 16'h0100, 16'h0000, 16'hFFFF, 1'b0, lat, rd, ce_low, bad, oth, wseen, ack_cnt);
        mdl_commit(1, 3'b011, 16'h0100, 16'h0000);
        n_checks++; if (lat !== 3 || rd !== exp_rd1) begin n_errors++; $display("FAIL rstmid_after: got lat=%0d rdata=%h expected 3/%h", lat, rd, exp_rd1); end
        n_checks++; if (oth || m0_rdata !== 16'h0000 || bad) begin n_errors++; $display("FAIL rstmid_m0_quiet: got ack=%b rdata=%h bad=%b expected 0/0000/0", oth, m0_rdata, bad); end
    endtask

    task automatic test_random();
        int lat, ce_low, ack_cnt, e, mst; logic [15:0] rd, wseen, addr, wdata, pat; bit bad, oth, drp;
        logic [2:0] cmd;
        for (int n = 0; n < 40; n++) begin
            mst   = int'($urandom_range(0, 1));
            cmd   = 3'($urandom_range(0, 7));
            addr  = 16'h0100 | 16'($urandom_range(0, 127) * 2);
            wdata = 16'($urandom);
            pat   = 16'($urandom) | 16'($urandom);
            drp   = ($urandom_range(0, 3) == 0);
            e     = exp_lat(cmd, pat);
            run_access(mst, cmd, addr, wdata, pat, drp, lat, rd, ce_low, bad, oth, wseen, ack_cnt);
            mdl_commit(mst, cmd, addr, wdata);
            n_checks++; if (lat !== e) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, e); end
            n_checks++; if (ce_low !== e - 1) begin n_errors++; $display("FAIL rnd_ce_low[%0d]: got %0d expected %0d", n, ce_low, e - 1); end
            n_checks++; if (bad) begin n_errors++; $display("FAIL rnd_bus[%0d]: got bad=1 expected stable addr/cmd/data", n); end
            n_checks++; if (oth || ack_cnt !== 1) begin n_errors++; $display("FAIL rnd_ack[%0d]: got other=%b acks=%0d expected 0/1", n, oth, ack_cnt); end
            n_checks++; if (m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", n, m0_rdata, m1_rdata, exp_rd0, exp_rd1); end
            if (!cmd[0]) begin
                n_checks++; if (wseen !== wdata) begin n_errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, wseen, wdata); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; reset_n = 1'b0;
        m0_req = 1'b0; m0_addr = 16'h0000; m0_cmd = 3'b000; m0_wdata = 16'h0000;
        m1_req = 1'b0; m1_addr = 16'h0000; m1_cmd = 3'b000; m1_wdata = 16'h0000;
        bus_wait_n = 1'b1;
        n_checks = 0; n_errors = 0;
        for (int i = 0; i < 256; i++) slv_mem[i] = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_wait_data();
        test_drop_req();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
